scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with enable; next generation of the team's 2-to-4 enable decoder.
- Adds a SCAN mode that walks the one-hot output through every position, holding each for a programmable dwell.
- Sits between control logic and select lines: mux selects, LED and column strobes, round-robin channel enables.

Parameters:
- SEL_W, 2, select width; output width OUT_W = 2**SEL_W; legal range 1..6.
- DWELL, 4, cycles each position is held in SCAN mode; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  enable; 0 forces all outputs low (next edge).
- mode  input  1  0 = DECODE, 1 = SCAN.
- a  input  SEL_W  select value in DECODE; start index on SCAN entry or load.
- load  input  1  SCAN only: reload index from a and restart dwell.
- b  output  OUT_W  registered one-hot output (all-zero when idle).
- idx  output  SEL_W  registered current index.
- wrap  output  1  one-cycle pulse when SCAN increments from OUT_W-1 to 0.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous and active-high on port reset.
  - Reset values: state=IDLE, b=0, idx=0, wrap=0, dwell_cnt=0.
  - Reset asserted mid-scan clears everything immediately, without waiting for a clock edge.
- All outputs are registered.
- Latency: 1 clk from sampled inputs to b/idx.
- States: IDLE, DECODE, SCAN. Next state is evaluated every edge with this priority:
  - en=0 -> IDLE; b=0, wrap=0; idx holds its last value.
  - en=1, mode=0 -> DECODE; idx=a, b=1<<a, wrap=0. a is tracked every cycle.
  - en=1, mode=1, current state != SCAN -> enter SCAN; idx=a, b=1<<a, dwell_cnt=0, wrap=0.
  - en=1, mode=1, in SCAN, load=1 -> idx=a, b=1<<a, dwell_cnt=0, wrap=0. load has priority over the dwell advance.
  - en=1, mode=1, in SCAN, load=0:
    - dwell_cnt < DWELL-1 -> dwell_cnt+1; idx and b hold.
    - dwell_cnt == DWELL-1 -> dwell_cnt=0, idx=idx+1 mod OUT_W, b=1<<(new idx).
    - wrap=1 only when this advance takes idx from OUT_W-1 to 0; otherwise wrap=0.
- Boundary rules:
  - DWELL=1: index advances every cycle; dwell_cnt stays 0.
  - Load to index 0, or entering SCAN at 0, never raises wrap.
  - SEL_W=1: OUT_W=2; scan alternates 01/10 and wrap fires on every 1->0 advance.
  - Mode change mid-scan: DECODE output appears on the next edge, and dwell_cnt is discarded.
  - Returning to SCAN restarts from a, never from the old idx.
  - en dropping mid-dwell aborts the scan; re-enable re-enters SCAN from a.
  - load is ignored in IDLE and DECODE.
- Invariants:
  - b is always either all-zero (IDLE, reset) or exactly one-hot with b[idx]=1.
  - wrap is never high for 2 consecutive cycles unless DWELL=1 and OUT_W=1.
  - OUT_W=1 is not a legal build, so that exception never occurs.
- Width rules:
  - dwell_cnt width = $clog2(DWELL+1), minimum 1.
  - idx increment is natural SEL_W-bit modulo arithmetic.
  - Shift 1<<idx is OUT_W bits wide, with no truncation.

Decomposition:
- Shared package scan_decoder_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_DECODE=2'd1, S_SCAN=2'd2.
  - mode constants MODE_DECODE=1'b0, MODE_SCAN=1'b1.
- One natural sub-module, onehot_dec: purely combinational SEL_W -> OUT_W binary-to-one-hot with enable. It is instantiated once to drive the b register input.
- FSM, dwell counter and index register stay in the top.

Test Plan (SEL_W=2, DWELL=3 unless stated):
- Reset: assert reset mid-scan between clock edges -> b=0000, idx=0, wrap=0 immediately. Hold en=0 for 5 clk -> outputs stay 0.
- DECODE sweep: en=1, mode=0, a=0,1,2,3 for 1 clk each -> b=0001,0010,0100,1000, each one clk after its a. Then en=0 -> b=0000 next clk.
- SCAN walk with wrap:
  - en=1, mode=1, a=2 -> b=0100 for 3 clk, then 1000 for 3 clk, then 0001 for 3 clk.
  - wrap=1 exactly on the cycle b becomes 0001.
  - Then 0010.
- Load priority: in SCAN at idx=1 with dwell_cnt=2, pulse load with a=3 -> next clk b=1000, dwell restarts (held 3 clk), wrap=0. Repeat with a=0 -> b=0001, wrap=0.
- Mode/enable interruption: mid-dwell switch mode=0 with a=1 -> b=0010 next clk. Back to mode=1 with a=3 -> b=1000 held 3 full clk. Drop en mid-dwell -> b=0000.
- DWELL=1, SEL_W=3 build: en=1, mode=1, a=6 -> b walks 0x40, 0x80, 0x01, 0x02 on consecutive clk. wrap high only with 0x01. Each b is one-hot with b[idx]=1 on every cycle.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// Shared constants for the scan_decoder block: FSM state encoding, mode values
// and the dwell counter width rule.
package scan_decoder_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Counter must hold 0..DWELL-1; never narrower than one bit.
  function automatic int dwell_w(input int d);
    if (d < 1) begin
      return 1;
    end else begin
      return $clog2(d + 1);
    end
  endfunction

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational binary-to-one-hot converter with enable; all-zero when disabled.
module onehot_dec #(
  parameter int SEL_W = 2
) (
  input  logic                  en_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [(2**SEL_W)-1:0] out_o
);

  localparam int OUT_W = 2 ** SEL_W;

  // Shift is carried out at full output width so no position is lost.
  always_comb begin
    out_o = '0;
    if (en_i) begin
      out_o = OUT_W'(1) << sel_i;
    end else begin
      out_o = '0;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a SCAN mode that walks the active
// output through every position, holding each one for DWELL cycles.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      a,
  input  logic                  load,
  output logic [(2**SEL_W)-1:0] b,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam int CNT_W = dwell_w(DWELL);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST   = {SEL_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             wrap_q, wrap_d;
  logic [OUT_W-1:0] b_q, b_d;

  // Priority: disable, decode, (re)entry or load into scan, then dwell advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      dwell_d = '0;
    end else if (mode == MODE_DECODE) begin
      state_d = S_DECODE;
      idx_d   = a;
      dwell_d = '0;
    end else if ((state_q != S_SCAN) || load) begin
      state_d = S_SCAN;
      idx_d   = a;
      dwell_d = '0;
    end else if (dwell_q != DWELL_LAST) begin
      dwell_d = dwell_q + CNT_W'(1);
    end else begin
      dwell_d = '0;
      idx_d   = idx_q + SEL_W'(1);
      wrap_d  = (idx_q == IDX_LAST);
    end
  end

  onehot_dec #(
    .SEL_W(SEL_W)
  ) u_dec (
    .en_i (en),
    .sel_i(idx_d),
    .out_o(b_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
      b_q     <= b_d;
    end
  end

  assign b    = b_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: a SEL_W=2/DWELL=3 build and a SEL_W=3/DWELL=1
// build run side by side against a position/time reference model.
module tb_scan_decoder;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b0;
  logic       mode  = 1'b0;
  logic       load  = 1'b0;
  logic [1:0] a     = 2'd0;
  logic [2:0] a2    = 3'd0;

  logic [3:0] b0;
  logic [1:0] idx0;
  logic       wrap0;
  logic [7:0] b1;
  logic [2:0] idx1;
  logic       wrap1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [63:0] b;
    int          idx;
    logic        wrap;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t mx0, mx1;

  // Model: per build, state, start index of the current scan and cycles since it began.
  int m_st[2]    = '{0, 0};
  int m_idx[2]   = '{0, 0};
  int m_start[2] = '{0, 0};
  int m_k[2]     = '{0, 0};
  int ow[2]      = '{4, 8};
  int dw[2]      = '{3, 1};

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(2), .DWELL(3)) dut0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .load(load),
    .b(b0), .idx(idx0), .wrap(wrap0)
  );

  scan_decoder #(.SEL_W(3), .DWELL(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a2), .load(load),
    .b(b1), .idx(idx1), .wrap(wrap1)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int u, input logic e, input logic m, input logic l,
                            input int av, output exp_t x);
    x.wrap = 1'b0;
    if (!e) begin
      m_st[u] = 0;
    end else if (!m) begin
      m_st[u]  = 1;
      m_idx[u] = av;
    end else if (m_st[u] != 2 || l) begin
      m_st[u]    = 2;
      m_start[u] = av;
      m_k[u]     = 0;
      m_idx[u]   = av;
    end else begin
      m_k[u]++;
      m_idx[u] = (m_start[u] + m_k[u] / dw[u]) % ow[u];
      x.wrap   = (m_k[u] % dw[u] == 0) && (m_idx[u] == 0);
    end
    x.idx = m_idx[u];
    x.b   = e ? (64'd1 << m_idx[u]) : 64'd0;
  endtask

  task automatic step(input logic e, input logic m, input int av0, input int av1, input logic l);
    exp_t x;
    @(negedge clk);
    en   = e;
    mode = m;
    a    = 2'(av0);
    a2   = 3'(av1);
    load = l;
    model_step(0, e, m, l, av0 % 4, x);
    q0.push_back(x);
    model_step(1, e, m, l, av1 % 8, x);
    q1.push_back(x);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_b0"}, 64'(b0), 64'd0);
    check({tag, "_idx0"}, 64'(idx0), 64'd0);
    check({tag, "_wrap0"}, 64'(wrap0), 64'd0);
    check({tag, "_b1"}, 64'(b1), 64'd0);
    check({tag, "_idx1"}, 64'(idx1), 64'd0);
    check({tag, "_wrap1"}, 64'(wrap1), 64'd0);
  endtask

  // Reset between edges must clear outputs without waiting for a clock.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    en    = 1'b0;
    #1;
    check_zero("async_rst");
    for (int u = 0; u < 2; u++) begin
      m_st[u]  = 0;
      m_idx[u] = 0;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every edge that has a pending expectation is compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      mx0 = q0.pop_front();
      check("b0", 64'(b0), mx0.b);
      check("idx0", 64'(idx0), 64'(mx0.idx));
      check("wrap0", 64'(wrap0), 64'(mx0.wrap));
      check("onehot0", {63'd0, (b0 == 4'd0) || ($onehot(b0) && b0[idx0])}, 64'd1);
    end
    if (q1.size() > 0) begin
      mx1 = q1.pop_front();
      check("b1", 64'(b1), mx1.b);
      check("idx1", 64'(idx1), 64'(mx1.idx));
      check("wrap1", 64'(wrap1), 64'(mx1.wrap));
      check("onehot1", {63'd0, (b1 == 8'd0) || ($onehot(b1) && b1[idx1])}, 64'd1);
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    repeat (5) step(1'b0, 1'b0, 0, 0, 1'b0);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, i, 2 * i + 1, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0);

    step(1'b1, 1'b1, 2, 6, 1'b0);
    repeat (11) step(1'b1, 1'b1, $urandom_range(0, 3), $urandom_range(0, 7), 1'b0);

    step(1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1, 1, 1'b0);
    repeat (2) step(1'b1, 1'b1, 2, 2, 1'b0);
    step(1'b1, 1'b1, 3, 7, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1, 1, 1'b0);
    step(1'b1, 1'b1, 0, 0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 2, 2, 1'b0);

    step(1'b1, 1'b0, 1, 5, 1'b0);
    step(1'b1, 1'b1, 3, 3, 1'b0);
    repeat (3) step(1'b1, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b1, 2, 2, 1'b1);
    step(1'b1, 1'b0, 2, 4, 1'b1);
    step(1'b1, 1'b1, 1, 6, 1'b0);
    step(1'b1, 1'b1, 1, 6, 1'b0);

    mid_reset();
    repeat (5) step(1'b0, 1'b0, $urandom_range(0, 3), $urandom_range(0, 7), 1'b0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7) == 0);
    end

    repeat (3) @(posedge clk);
    #2;
    check("drain", 64'(q0.size() + q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
